// File: rtl/vc_bimodal_predictor_if.sv
// Request/response/update bundle for the bimodal branch predictor.
// The master side issues prediction requests and resolved-branch updates.
// The slave side (the predictor) returns the prediction and readiness.
interface vc_bimodal_predictor_if #(
    parameter int PC_SZ = 32
);
    logic             req_val;
    logic             req_rdy;
    logic [PC_SZ-1:0] req_pc;
    logic             resp_val;
    logic             resp_taken;
    logic             upd_val;
    logic [PC_SZ-1:0] upd_pc;
    logic             upd_taken;
    logic             init_done;

    modport master (
        output req_val, req_pc, upd_val, upd_pc, upd_taken,
        input  req_rdy, resp_val, resp_taken, init_done
    );

    modport slave (
        input  req_val, req_pc, upd_val, upd_pc, upd_taken,
        output req_rdy, resp_val, resp_taken, init_done
    );
endinterface

// File: rtl/vc_bimodal_predictor.sv
// Bimodal branch direction predictor: a table of 2-bit saturating counters
// indexed by pc[IDX_SZ+1:2]. After reset the table is swept to INIT_CTR,
// one entry per cycle, before requests are accepted.
module vc_bimodal_predictor #(
    parameter int         IDX_SZ   = 6,
    parameter int         PC_SZ    = 32,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    vc_bimodal_predictor_if.slave   bus
);
    localparam int DEPTH = 1 << IDX_SZ;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        r_state;
    logic [IDX_SZ-1:0] r_sweep;
    logic              r_resp_val;
    logic              r_resp_taken;
    logic [1:0]        r_table [DEPTH];

    logic [IDX_SZ-1:0] w_req_idx;
    logic [IDX_SZ-1:0] w_upd_idx;
    logic              w_ready;
    logic              w_fire;
    logic [1:0]        w_upd_cur;
    logic [1:0]        w_upd_next;
    logic              w_unused;

    assign w_req_idx = bus.req_pc[IDX_SZ+1:2];
    assign w_upd_idx = bus.upd_pc[IDX_SZ+1:2];
    assign w_ready   = (r_state == ST_READY);
    assign w_fire    = bus.req_val & w_ready;
    assign w_upd_cur = r_table[w_upd_idx];

    // Only the index bits of the PCs matter; the rest are folded here.
    assign w_unused = ^{bus.req_pc, bus.upd_pc};

    // Saturating counter step for the resolved branch.
    always_comb begin
        w_upd_next = w_upd_cur;
        if (bus.upd_taken) begin
            if (w_upd_cur != 2'b11) w_upd_next = w_upd_cur + 2'b01;
        end else begin
            if (w_upd_cur != 2'b00) w_upd_next = w_upd_cur - 2'b01;
        end
    end

    // State machine: sweep every entry once, then stay READY until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + 1'b1;
            if (r_sweep == {IDX_SZ{1'b1}}) r_state <= ST_READY;
        end
    end

    // Single table write port: the init sweep owns it in INIT, updates in READY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_table[r_sweep] <= INIT_CTR;
            end else if (bus.upd_val) begin
                r_table[w_upd_idx] <= w_upd_next;
            end
        end
    end

    // Registered response; reads the pre-update counter on a same-index update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_val   <= 1'b0;
            r_resp_taken <= 1'b0;
        end else begin
            r_resp_val <= w_fire;
            if (w_fire) r_resp_taken <= r_table[w_req_idx][1];
        end
    end

    assign bus.req_rdy    = w_ready;
    assign bus.init_done  = w_ready;
    assign bus.resp_val   = r_resp_val;
    assign bus.resp_taken = r_resp_taken;
endmodule

// File: tb/tb_vc_bimodal_predictor.sv
// Self-checking bench for vc_bimodal_predictor (IDX_SZ=6, INIT_CTR=01).
module tb_vc_bimodal_predictor;
    logic clk = 1'b0;
    logic reset;

    vc_bimodal_predictor_if #(.PC_SZ(32)) bus ();

    vc_bimodal_predictor #(
        .IDX_SZ  (6),
        .PC_SZ   (32),
        .INIT_CTR(2'b01)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int model [64];

    typedef struct {
        bit          is_req;
        logic [31:0] pc;
        bit          taken;
        bit          exp_taken;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else            n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int pidx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic void model_upd(input logic [31:0] pc, input bit taken);
        int i;
        i = pidx(pc);
        if (taken) model[i] = (model[i] < 3) ? model[i] + 1 : 3;
        else       model[i] = (model[i] > 0) ? model[i] - 1 : 0;
    endfunction

    function automatic void model_init;
        for (int i = 0; i < 64; i++) model[i] = 1;
    endfunction

    task automatic do_update(input logic [31:0] pc, input bit taken);
        bus.upd_val   = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = taken;
        step;
        bus.upd_val = 1'b0;
        model_upd(pc, taken);
        $display("upd  pc=%08h taken=%0d ctr=%0d", pc, taken, model[pidx(pc)]);
    endtask

    task automatic do_request(input logic [31:0] pc, output bit v, output bit t);
        bus.req_val = 1'b1;
        bus.req_pc  = pc;
        step;
        bus.req_val = 1'b0;
        v = bus.resp_val;
        t = bus.resp_taken;
        $display("req  pc=%08h resp_val=%0d resp_taken=%0d", pc, v, t);
    endtask

    // Counts cycles until req_rdy rises (bounded), noting any resp_val seen.
    task automatic wait_ready(output int cnt, output bit saw_resp);
        cnt      = 0;
        saw_resp = 1'b0;
        while (cnt < 200) begin
            step;
            cnt++;
            if (bus.resp_val) saw_resp = 1'b1;
            if (bus.req_rdy) break;
        end
    endtask

    initial begin
        bit          v, t, exp_t, prev_t;
        int          cnt;
        bit          saw;
        logic [31:0] rpc, upc;
        bit          rv, uv, ut;

        vecs[0]  = '{1'b0, 32'h100, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h100, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h100, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h100, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h100, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h100, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h004, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h004, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h104, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 32'h008, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FF3F, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.req_val   = 1'b0;
        bus.req_pc    = '0;
        bus.upd_val   = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_taken = 1'b0;
        repeat (2) step;

        chk("reset_req_rdy",    int'(bus.req_rdy),    0);
        chk("reset_init_done",  int'(bus.init_done),  0);
        chk("reset_resp_val",   int'(bus.resp_val),   0);
        chk("reset_resp_taken", int'(bus.resp_taken), 0);

        // Requests and updates during INIT must be ignored.
        bus.req_val   = 1'b1;
        bus.req_pc    = 32'h100;
        bus.upd_val   = 1'b1;
        bus.upd_pc    = 32'h100;
        bus.upd_taken = 1'b1;
        reset         = 1'b0;
        wait_ready(cnt, saw);
        bus.req_val = 1'b0;
        bus.upd_val = 1'b0;
        chk("init_cycles",        cnt,             64);
        chk("init_no_resp",       int'(saw),       0);
        chk("init_done_after",    int'(bus.init_done), 1);
        model_init();

        do_request(32'h3C, v, t);
        chk("first_req_val",   int'(v), 1);
        chk("first_req_taken", int'(t), 0);
        do_request(32'h100, v, t);
        chk("init_upd_ignored", int'(t), 0);

        // Training, hysteresis and aliasing vectors.
        foreach (vecs[i]) begin
            if (vecs[i].is_req) begin
                do_request(vecs[i].pc, v, t);
                chk($sformatf("vec%0d_val", i),   int'(v), 1);
                chk($sformatf("vec%0d_taken", i), int'(t), int'(vecs[i].exp_taken));
            end else begin
                do_update(vecs[i].pc, vecs[i].taken);
            end
        end

        // Same-index collision: response sees the pre-update counter.
        bus.req_val   = 1'b1;
        bus.req_pc    = 32'h40;
        bus.upd_val   = 1'b1;
        bus.upd_pc    = 32'h40;
        bus.upd_taken = 1'b1;
        step;
        bus.req_val = 1'b0;
        bus.upd_val = 1'b0;
        model_upd(32'h40, 1'b1);
        $display("coll pc=00000040 resp_val=%0d resp_taken=%0d", bus.resp_val, bus.resp_taken);
        chk("collision_val",   int'(bus.resp_val),   1);
        chk("collision_taken", int'(bus.resp_taken), 0);
        do_request(32'h40, v, t);
        chk("collision_after", int'(t), 1);

        // Back-to-back requests, one per cycle.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req_val = 1'b1;
            bus.req_pc  = 32'h200 + 32'(i * 4);
            exp_t       = (model[pidx(bus.req_pc)] >= 2);
            step;
            $display("b2b  pc=%08h resp_val=%0d resp_taken=%0d", bus.req_pc, bus.resp_val, bus.resp_taken);
            if (bus.resp_val) cnt++;
            chk($sformatf("b2b%0d_taken", i), int'(bus.resp_taken), int'(exp_t));
            prev_t = exp_t;
        end
        bus.req_val = 1'b0;
        chk("b2b_val_count", cnt, 10);
        step;
        chk("idle_resp_val",   int'(bus.resp_val),   0);
        chk("idle_taken_hold", int'(bus.resp_taken), int'(prev_t));

        // Randomized traffic against the counter-array model.
        prev_t = bus.resp_taken;
        for (int n = 0; n < 300; n++) begin
            rv  = ($urandom_range(0, 2) != 0);
            uv  = ($urandom_range(0, 1) != 0);
            ut  = ($urandom_range(0, 1) != 0);
            rpc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2);
            upc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2);
            bus.req_val   = rv;
            bus.req_pc    = rpc;
            bus.upd_val   = uv;
            bus.upd_pc    = upc;
            bus.upd_taken = ut;
            exp_t = rv ? (model[pidx(rpc)] >= 2) : prev_t;
            step;
            if (uv) model_upd(upc, ut);
            $display("rnd%0d req=%0d pc=%08h upd=%0d pc=%08h t=%0d -> val=%0d taken=%0d",
                     n, rv, rpc, uv, upc, ut, bus.resp_val, bus.resp_taken);
            chk($sformatf("rnd%0d_val", n),   int'(bus.resp_val),   int'(rv));
            chk($sformatf("rnd%0d_taken", n), int'(bus.resp_taken), int'(exp_t));
            prev_t = exp_t;
        end
        bus.req_val = 1'b0;
        bus.upd_val = 1'b0;

        // Reset mid-READY with a request in flight.
        do_update(32'h100, 1'b1);
        do_update(32'h100, 1'b1);
        do_update(32'h100, 1'b1);
        do_request(32'h100, v, t);
        chk("trained_taken", int'(t), 1);
        reset       = 1'b1;
        bus.req_val = 1'b1;
        bus.req_pc  = 32'h100;
        step;
        bus.req_val = 1'b0;
        chk("midreset_resp_val",   int'(bus.resp_val),   0);
        chk("midreset_resp_taken", int'(bus.resp_taken), 0);
        chk("midreset_req_rdy",    int'(bus.req_rdy),    0);
        reset = 1'b0;
        wait_ready(cnt, saw);
        chk("reinit_cycles", cnt,       64);
        chk("reinit_no_resp", int'(saw), 0);
        model_init();
        do_request(32'h100, v, t);
        chk("reinit_val",   int'(v), 1);
        chk("reinit_taken", int'(t), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
